// File: rtl/resource_arbiter.sv
// rtl/resource_arbiter.sv - round-robin arbiter sequencing N_REQ requesters onto one shared resource
// Optional watchdog in WAIT: define RESOURCE_ARB_TIMEOUT_EN.
module resource_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic [N_REQ-1:0]          resp_valid_o,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic [DATA_W-1:0]         res_input_o,
    output logic                      res_valid_o,
    input  logic [DATA_W-1:0]         res_output_i,
    input  logic                      res_out_valid_i,
    output logic                      busy_o,
    output logic                      timeout_err_o
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [DATA_W-1:0]   res_input_q, res_input_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;

    logic                found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;

`ifdef RESOURCE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
    logic [31:0]         timeout_param_unused;
    assign timeout_param_unused = TIMEOUT_CYCLES;
`endif

    // Rotating priority search: first requesting index at or above ptr, wrapping
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Next-state and registered-output computation for the IDLE/ISSUE/WAIT/RESP sequence
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        resp_data_d   = resp_data_q;
        res_input_d   = res_input_q;
        res_valid_d   = 1'b0;
        resp_valid_d  = '0;
        timeout_err_d = 1'b0;
`ifdef RESOURCE_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d          = S_ISSUE;
                    owner_d          = sel_idx;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    res_input_d      = req_data_i[sel_idx*DATA_W +: DATA_W];
                    res_valid_d      = 1'b1;
                end
            end
            S_ISSUE: begin
                // A result strobe here is ignored: the resource needs at least one cycle
                state_d = S_WAIT;
`ifdef RESOURCE_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (res_out_valid_i) begin
                    resp_data_d  = res_output_i;
                    resp_valid_d = grant_q;
                    state_d      = S_RESP;
                end
`ifdef RESOURCE_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d   = '0;
                    resp_valid_d  = grant_q;
                    timeout_err_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any in-flight transaction
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
            res_input_q   <= '0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef RESOURCE_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            res_input_q   <= res_input_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
`ifdef RESOURCE_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign grant_o       = grant_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_data_o   = resp_data_q;
    assign res_input_o   = res_input_q;
    assign res_valid_o   = res_valid_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// tb/tb_resource_arbiter.sv - self-checking bench for resource_arbiter
module tb_resource_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [DW-1:0]   words [N];
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant, resp_valid;
    logic [DW-1:0]   resp_data, res_input, res_output;
    logic            res_valid, res_out_valid, busy, timeout_err;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    assign req_data = {words[3], words[2], words[1], words[0]};

    resource_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .req_data_i(req_data),
        .grant_o(grant), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .res_input_o(res_input), .res_valid_o(res_valid), .res_output_i(res_output),
        .res_out_valid_i(res_out_valid), .busy_o(busy), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        int           lat;
        int           win;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".grant"}, 32'(grant), 32'd0);
        chk({nm, ".resp_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, ".res_valid"}, 32'(res_valid), 32'd0);
        chk({nm, ".busy"}, 32'(busy), 32'd0);
    endtask

    // Round-robin rule of the reference model: first set request from mptr upward, wrapping
    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    // One full transaction; result is what the resource returns after lat WAIT cycles
    task automatic do_txn(input logic [N-1:0] r, input int lat, input int w,
                          input bit drop, input logic [DW-1:0] result);
        logic [N-1:0] oh;
        oh = N'(1) << w;
        req = r;
        tick();
        chk("issue.grant", 32'(grant), 32'(oh));
        chk("issue.res_valid", 32'(res_valid), 32'd1);
        chk("issue.res_input", res_input, words[w]);
        chk("issue.busy", 32'(busy), 32'd1);
        req = N'($urandom);
        res_out_valid = 1'($urandom_range(0, 1));
        tick();
        req = drop ? '0 : r;
        res_out_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk("wait.grant", 32'(grant), 32'(oh));
            chk("wait.res_valid", 32'(res_valid), 32'd0);
            chk("wait.resp_valid", 32'(resp_valid), 32'd0);
            if (k == lat) begin
                res_out_valid = 1'b1;
                res_output    = result;
            end
            tick();
            res_out_valid = 1'b0;
        end
        chk("resp.resp_valid", 32'(resp_valid), 32'(oh));
        chk("resp.resp_data", resp_data, result);
        chk("resp.grant", 32'(grant), 32'(oh));
        chk("resp.timeout_err", 32'(timeout_err), 32'd0);
        res_out_valid = 1'($urandom_range(0, 1));
        res_output    = $urandom;
        req = r;
        tick();
        res_out_valid = 1'b0;
        chk_idle("post");
        mptr = (w + 1) % N;
    endtask

    initial begin
        vecs[0] = '{4'b1111, 1, 0};
        vecs[1] = '{4'b1111, 2, 1};
        vecs[2] = '{4'b1111, 3, 2};
        vecs[3] = '{4'b1111, 1, 3};
        vecs[4] = '{4'b1111, 1, 0};
        vecs[5] = '{4'b0100, 2, 2};
        vecs[6] = '{4'b1001, 1, 3};
        vecs[7] = '{4'b1001, 2, 0};
        vecs[8] = '{4'b0110, 4, 1};
        vecs[9] = '{4'b0011, 1, 0};

        reset = 1'b1;
        req = '0;
        res_out_valid = 1'b0;
        res_output = '0;
        for (int i = 0; i < N; i++) words[i] = $urandom;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset");
        chk("reset.res_input", res_input, 32'd0);
        chk("reset.resp_data", resp_data, 32'd0);
        chk("reset.timeout_err", 32'(timeout_err), 32'd0);

        // Fairness from reset, then wrap around ptr
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) words[j] = $urandom;
            do_txn(vecs[i].r, vecs[i].lat, vecs[i].win, 1'b0, words[vecs[i].win] + 32'd1);
        end

        // Single request with a recognisable operand; ptr is 1 here
        words[2] = 32'hDEADBEEF;
        do_txn(4'b0100, 3, 2, 1'b0, 32'hDEADBEF0);

        // Requester drops req during WAIT; ptr is 3 here
        words[0] = 32'h0000_1234;
        do_txn(4'b0001, 2, 0, 1'b1, 32'h0000_1235);

        // Stray result strobes while idle
        req = '0;
        for (int i = 0; i < 2; i++) begin
            res_out_valid = 1'b1;
            res_output    = 32'hBAD0_0000;
            tick();
            chk_idle("stray");
        end
        res_out_valid = 1'b0;

        // Reset pulsed mid-WAIT, then the resource answers late
        req = 4'b0010;
        tick();
        chk("rst.issue_grant", 32'(grant), 32'b0010);
        req = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst");
        chk("rst.res_input", res_input, 32'd0);
        chk("rst.resp_data", resp_data, 32'd0);
        res_out_valid = 1'b1;
        res_output    = 32'h5555_5555;
        tick();
        res_out_valid = 1'b0;
        chk_idle("rst.late");
        mptr = 0;
        do_txn(4'b1111, 1, 0, 1'b0, words[0] + 32'd1);

        // Randomised transactions against the round-robin model
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] r;
            int w;
            for (int j = 0; j < N; j++) words[j] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                res_out_valid = 1'($urandom_range(0, 1));
                tick();
                res_out_valid = 1'b0;
                chk_idle("rnd.idle");
            end
            r = N'($urandom_range(1, 15));
            w = model_pick(r);
            do_txn(r, $urandom_range(1, 6), w, 1'($urandom_range(0, 1)), $urandom);
        end

`ifdef RESOURCE_ARB_TIMEOUT_EN
        // Watchdog: no response
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        for (int k = 1; k < 8; k++) begin
            chk("to.wait_resp_valid", 32'(resp_valid), 32'd0);
            tick();
        end
        chk("to.last_wait_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        chk("to.resp_valid", 32'(resp_valid), 32'(N'(1) << model_pick(4'b0001)));
        chk("to.timeout_err", 32'(timeout_err), 32'd1);
        chk("to.resp_data", resp_data, 32'd0);
        tick();
        chk_idle("to.post");
        mptr = 1;
        // Response on the limit cycle wins over the watchdog
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        for (int k = 1; k < 8; k++) tick();
        res_out_valid = 1'b1;
        res_output    = 32'h0000_BEEF;
        tick();
        res_out_valid = 1'b0;
        chk("tw.resp_valid", 32'(resp_valid), 32'b0010);
        chk("tw.timeout_err", 32'(timeout_err), 32'd0);
        chk("tw.resp_data", resp_data, 32'h0000_BEEF);
        tick();
`else
        // Without the watchdog WAIT lasts until the resource answers
        req = 4'b0001;
        tick();
        req = '0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k % 10 == 9) chk("nowd.busy", 32'(busy), 32'd1);
        end
        chk("nowd.resp_valid", 32'(resp_valid), 32'd0);
        res_out_valid = 1'b1;
        res_output    = 32'h0000_0077;
        tick();
        res_out_valid = 1'b0;
        chk("nowd.late_resp", 32'(resp_valid), 32'b0001);
        chk("nowd.timeout_err", 32'(timeout_err), 32'd0);
        tick();
        chk_idle("nowd.post");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
